// File: rtl/pc_redirect_fetch_pkg.sv
// Shared RV32 fetch definitions.
//  - fetch_state_e : IF-stage sequencer states
//  - pc_sel_e      : next-PC source select driven into pc_next_mux
//  - XLEN_DEF, RESET_PC_DEF, INSTR_BYTES constants
//  - is_word_aligned() : low-address-bit alignment test for redirect targets
package rv32_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned INSTR_BYTES  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DROP = 2'b10
  } fetch_state_e;

  typedef enum logic [1:0] {
    SEL_HOLD    = 2'b00,
    SEL_INC     = 2'b01,
    SEL_TARGET  = 2'b10,
    SEL_PENDING = 2'b11
  } pc_sel_e;

  // A target is usable only if it lands on a 32-bit instruction boundary.
  function automatic logic is_word_aligned(input logic [1:0] addr_lo);
    return (addr_lo == 2'b00);
  endfunction

endpackage

// File: rtl/pc_redirect_fetch_if.sv
// Fetch-side bundle between the IF sequencer, the EX branch resolution,
// the hazard unit and instruction memory.
//  master : the fetch sequencer (drives imem_req, PC, flushes, ...)
//  slave  : the surrounding pipeline / IMEM
interface pc_redirect_fetch_if #(
  parameter int unsigned XLEN = 32
);
  logic            PCAddressController;
  logic [XLEN-1:0] TargetedAddress;
  logic            Stall;
  logic            imem_ready;
  logic            imem_req;
  logic [XLEN-1:0] PC;
  logic [XLEN-1:0] PC_plus4;
  logic            IF_valid;
  logic            Flush_IFID;
  logic            Flush_IDEX;
  logic            Misaligned;

  modport master (
    input  PCAddressController, TargetedAddress, Stall, imem_ready,
    output imem_req, PC, PC_plus4, IF_valid, Flush_IFID, Flush_IDEX, Misaligned
  );

  modport slave (
    output PCAddressController, TargetedAddress, Stall, imem_ready,
    input  imem_req, PC, PC_plus4, IF_valid, Flush_IFID, Flush_IDEX, Misaligned
  );
endinterface

// File: rtl/pc_redirect_fetch_pc_next_mux.sv
// Next-PC selector.
//  pc       in  current fetch address
//  target   in  redirect target from EX
//  pending  in  redirect target parked while a wrong-path fetch drains
//  sel      in  source select
//  pc_plus4 out pc + 4 (modulo 2^XLEN)
//  pc_next  out selected next PC
module pc_next_mux
  import rv32_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] target,
  input  logic [XLEN-1:0] pending,
  input  pc_sel_e         sel,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] pc_next
);

  // Sequential increment; wraps silently at the top of the address space.
  assign pc_plus4 = pc + XLEN'(INSTR_BYTES);

  // Pick the next fetch address.
  always_comb begin
    pc_next = pc;
    case (sel)
      SEL_HOLD:    pc_next = pc;
      SEL_INC:     pc_next = pc_plus4;
      SEL_TARGET:  pc_next = target;
      SEL_PENDING: pc_next = pending;
      default:     pc_next = pc;
    endcase
  end

endmodule

// File: rtl/pc_redirect_fetch.sv
// IF-stage PC and fetch sequencer for the RV32IM pipeline.
//  CLK    in  rising-edge clock
//  RESET  in  asynchronous active-low reset
//  fetch  master modport: branch redirect inputs, stall, IMEM handshake,
//         PC / PC_plus4 / IF_valid and squash / misalignment outputs.
// A redirect that arrives while a fetch is still outstanding is parked in
// pending_r; the sequencer waits in DROP (keeping PC stable for the
// handshake) until that wrong-path response is consumed and discarded.
module pc_redirect_fetch
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned XLEN     = XLEN_DEF
) (
  input logic                 CLK,
  input logic                 RESET,
  pc_redirect_fetch_if.master fetch
);

  fetch_state_e    state_r;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pending_r;
  logic            if_valid_r;

  logic            take_s;
  logic            misaligned_s;
  logic            req_s;
  logic            fire_s;
  logic            flush_s;
  pc_sel_e         sel_s;
  logic [XLEN-1:0] pc_next_s;
  logic [XLEN-1:0] pc_plus4_s;

  // Redirect qualification, request gating and squash generation.
  // A taken redirect overrides a load-use stall because the EX branch is older.
  always_comb begin
    take_s       = fetch.PCAddressController && is_word_aligned(fetch.TargetedAddress[1:0]);
    misaligned_s = fetch.PCAddressController && !is_word_aligned(fetch.TargetedAddress[1:0]);
    req_s        = (state_r != IDLE) && !(fetch.Stall && (state_r == RUN) && !take_s);
    fire_s       = req_s && fetch.imem_ready;
    flush_s      = take_s && (state_r != IDLE);
  end

  // Next-PC source decision.
  always_comb begin
    sel_s = SEL_HOLD;
    case (state_r)
      RUN: begin
        if (take_s) begin
          if (req_s && !fetch.imem_ready) sel_s = SEL_HOLD;
          else                            sel_s = SEL_TARGET;
        end else if (fetch.Stall) begin
          sel_s = SEL_HOLD;
        end else if (fire_s) begin
          sel_s = SEL_INC;
        end else begin
          sel_s = SEL_HOLD;
        end
      end
      DROP: begin
        // The newest redirect wins if it coincides with the drain completing.
        if (fetch.imem_ready) begin
          if (take_s) sel_s = SEL_TARGET;
          else        sel_s = SEL_PENDING;
        end else begin
          sel_s = SEL_HOLD;
        end
      end
      default: sel_s = SEL_HOLD;
    endcase
  end

  pc_next_mux #(.XLEN(XLEN)) u_pc_next_mux (
    .pc       (pc_r),
    .target   (fetch.TargetedAddress),
    .pending  (pending_r),
    .sel      (sel_s),
    .pc_plus4 (pc_plus4_s),
    .pc_next  (pc_next_s)
  );

  // Fetch FSM with PC, pending-target and IF_valid registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r    <= IDLE;
      pc_r       <= XLEN'(RESET_PC);
      pending_r  <= '0;
      if_valid_r <= 1'b0;
    end else begin
      pc_r <= pc_next_s;
      case (state_r)
        IDLE: begin
          state_r    <= RUN;
          if_valid_r <= 1'b0;
        end
        RUN: begin
          if (take_s) begin
            if_valid_r <= 1'b0;
            if (req_s && !fetch.imem_ready) begin
              pending_r <= fetch.TargetedAddress;
              state_r   <= DROP;
            end else begin
              state_r <= RUN;
            end
          end else if (fetch.Stall) begin
            // IF/ID contents are frozen while the hazard unit stalls.
            if_valid_r <= if_valid_r;
            state_r    <= RUN;
          end else begin
            if_valid_r <= fire_s;
            state_r    <= RUN;
          end
        end
        DROP: begin
          if_valid_r <= 1'b0;
          if (fetch.imem_ready) begin
            state_r <= RUN;
          end else begin
            state_r <= DROP;
            if (take_s) pending_r <= fetch.TargetedAddress;
            else        pending_r <= pending_r;
          end
        end
        default: begin
          state_r    <= IDLE;
          if_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign fetch.imem_req   = req_s;
  assign fetch.PC         = pc_r;
  assign fetch.PC_plus4   = pc_plus4_s;
  assign fetch.IF_valid   = if_valid_r;
  assign fetch.Flush_IFID = flush_s;
  assign fetch.Flush_IDEX = flush_s;
  assign fetch.Misaligned = misaligned_s;

endmodule

// File: tb/tb_pc_redirect_fetch.sv
// Directed bench for pc_redirect_fetch: sequential fetch, stall, redirects
// with and without an outstanding fetch, misaligned targets, reset during
// DROP and PC wrap-around.
module tb_pc_redirect_fetch;

  logic CLK;
  logic RESET;
  int   checks;
  int   failures;

  pc_redirect_fetch_if #(.XLEN(32)) bus ();

  pc_redirect_fetch #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .fetch (bus.master)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_in(input logic br, input logic [31:0] tgt, input logic stall, input logic rdy);
    bus.PCAddressController = br;
    bus.TargetedAddress     = tgt;
    bus.Stall               = stall;
    bus.imem_ready          = rdy;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RESET    = 1'b0;
    set_in(1'b0, 32'h0, 1'b0, 1'b1);
    #12;
    // Reset state
    check("rst_pc",       bus.PC,         32'h0);
    check("rst_req",      bus.imem_req,   32'h0);
    check("rst_valid",    bus.IF_valid,   32'h0);
    check("rst_flush_if", bus.Flush_IFID, 32'h0);
    check("rst_flush_ex", bus.Flush_IDEX, 32'h0);
    check("rst_misalign", bus.Misaligned, 32'h0);
    RESET = 1'b1;

    // 1: sequential fetch after reset release
    tick();
    check("t1_req",    bus.imem_req, 32'h1);
    check("t1_pc0",    bus.PC,       32'h0);
    check("t1_valid0", bus.IF_valid, 32'h0);
    tick();
    check("t1_pc4",    bus.PC,       32'h4);
    check("t1_valid1", bus.IF_valid, 32'h1);
    tick();
    check("t1_pc8",    bus.PC,       32'h8);
    tick();
    check("t1_pc12",   bus.PC,       32'hC);
    tick();
    check("t1_pc16",   bus.PC,       32'h10);
    check("t1_plus4",  bus.PC_plus4, 32'h14);

    // 2: load-use stall for two cycles
    set_in(1'b0, 32'h0, 1'b1, 1'b1);
    #1;
    check("t2_req_stall", bus.imem_req, 32'h0);
    tick();
    check("t2_pc_hold1",  bus.PC,       32'h10);
    check("t2_valid_h1",  bus.IF_valid, 32'h1);
    tick();
    check("t2_pc_hold2",  bus.PC,       32'h10);
    check("t2_valid_h2",  bus.IF_valid, 32'h1);
    set_in(1'b0, 32'h0, 1'b0, 1'b1);
    #1;
    check("t2_req_rel",   bus.imem_req, 32'h1);
    tick();
    check("t2_pc_next",   bus.PC,       32'h14);
    tick();
    tick();
    tick();
    check("t3_pc_start",  bus.PC,       32'h20);

    // 3: taken redirect with IMEM ready
    set_in(1'b1, 32'h100, 1'b0, 1'b1);
    #1;
    check("t3_flush_if",  bus.Flush_IFID, 32'h1);
    check("t3_flush_ex",  bus.Flush_IDEX, 32'h1);
    check("t3_misalign",  bus.Misaligned, 32'h0);
    tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b1);
    check("t3_pc_tgt",    bus.PC,       32'h100);
    check("t3_valid0",    bus.IF_valid, 32'h0);
    #1;
    check("t3_noflush",   bus.Flush_IFID, 32'h0);
    tick();
    check("t3_pc_104",    bus.PC,       32'h104);
    check("t3_valid1",    bus.IF_valid, 32'h1);

    // Move to 0x40 with a ready redirect
    set_in(1'b1, 32'h40, 1'b0, 1'b1);
    tick();
    check("t4_pc_start",  bus.PC,       32'h40);

    // 4: redirect while the fetch is outstanding -> DROP
    set_in(1'b1, 32'h200, 1'b0, 1'b0);
    #1;
    check("t4_flush_ex",  bus.Flush_IDEX, 32'h1);
    tick();
    set_in(1'b0, 32'h0, 1'b1, 1'b0);
    check("t4_pc_hold",   bus.PC,       32'h40);
    check("t4_valid0",    bus.IF_valid, 32'h0);
    #1;
    check("t4_req_drop",  bus.imem_req, 32'h1);
    check("t4_noflush",   bus.Flush_IFID, 32'h0);
    tick();
    check("t4_pc_hold2",  bus.PC,       32'h40);
    set_in(1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b1);
    check("t4_pc_tgt",    bus.PC,       32'h200);
    check("t4_valid_d",   bus.IF_valid, 32'h0);
    tick();
    check("t4_pc_204",    bus.PC,       32'h204);
    check("t4_valid1",    bus.IF_valid, 32'h1);

    // 5: misaligned target, then redirect racing a stall
    set_in(1'b1, 32'h102, 1'b0, 1'b1);
    #1;
    check("t5_misalign",  bus.Misaligned, 32'h1);
    check("t5_noflush",   bus.Flush_IFID, 32'h0);
    tick();
    check("t5_pc_seq",    bus.PC,       32'h208);
    check("t5_valid",     bus.IF_valid, 32'h1);
    set_in(1'b1, 32'h80, 1'b1, 1'b1);
    #1;
    check("t5_req_win",   bus.imem_req, 32'h1);
    check("t5_flush_win", bus.Flush_IDEX, 32'h1);
    check("t5_misal0",    bus.Misaligned, 32'h0);
    tick();
    check("t5_pc_tgt",    bus.PC,       32'h80);
    check("t5_valid0",    bus.IF_valid, 32'h0);

    // 6: reset while in DROP with pending 0x300
    set_in(1'b1, 32'h300, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    check("t6_pc_drop",   bus.PC,       32'h80);
    #1;
    RESET = 1'b0;
    #1;
    check("t6_rst_pc",    bus.PC,       32'h0);
    check("t6_rst_valid", bus.IF_valid, 32'h0);
    check("t6_rst_req",   bus.imem_req, 32'h0);
    #3;
    set_in(1'b0, 32'h0, 1'b0, 1'b1);
    RESET = 1'b1;
    tick();
    check("t6_pc_idle",   bus.PC,       32'h0);
    tick();
    check("t6_pc_4",      bus.PC,       32'h4);

    // Wrap-around of PC + 4
    set_in(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b1);
    check("wrap_pc",      bus.PC,       32'hFFFF_FFFC);
    check("wrap_plus4",   bus.PC_plus4, 32'h0);
    tick();
    check("wrap_pc0",     bus.PC,       32'h0);
    check("wrap_valid",   bus.IF_valid, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
